// File: rtl/wb_router_pkg.sv
// rtl/wb_router_pkg.sv - shared types and helpers for the wishbone address router
package wb_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // OR-reduction of bit positions; exact for a one-hot input
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// rtl/wb_addr_match.sv - per-slave prefix/mask comparators with lowest-index priority
module wb_addr_match #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 32
) (
  input  logic [ADDR_W-1:0]            adr_i,
  input  logic [NUM_SLAVES*ADDR_W-1:0] prefix_i,
  input  logic [NUM_SLAVES*ADDR_W-1:0] mask_i,
  output logic                         match_valid_o,
  output logic [NUM_SLAVES-1:0]        match_oh_o
);

  logic [NUM_SLAVES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      hit[k] = ((adr_i & mask_i[k*ADDR_W +: ADDR_W]) ^ prefix_i[k*ADDR_W +: ADDR_W]) == '0;
    end
  end

  // isolate the lowest set bit so overlapping windows resolve to the lowest index
  assign match_oh_o    = hit & (~hit + 1'b1);
  assign match_valid_o = |hit;

endmodule

// File: rtl/wb_addr_router.sv
// rtl/wb_addr_router.sv - 1-to-N wishbone classic router with decode error and timeout
module wb_addr_router
  import wb_router_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  input  logic                         m_we_i,
  input  logic [ADDR_W-1:0]            m_adr_i,
  input  logic [DATA_W-1:0]            m_dat_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  input  logic [NUM_SLAVES*ADDR_W-1:0] slv_adr_prefix_i,
  input  logic [NUM_SLAVES*ADDR_W-1:0] slv_adr_mask_i,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  input  logic [NUM_SLAVES-1:0]        s_err_i,
  output logic                         timeout_o
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d, match_oh;
  logic                  match_valid;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_d, err_d, to_d, latch_req, cap_dat;
  logic [3:0]            sel_idx;
  logic                  slv_ack, slv_err;

  wb_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W)
  ) u_match (
    .adr_i         (m_adr_i),
    .prefix_i      (slv_adr_prefix_i),
    .mask_i        (slv_adr_mask_i),
    .match_valid_o (match_valid),
    .match_oh_o    (match_oh)
  );

  assign sel_idx = onehot_to_idx(16'(sel_q));
  assign slv_ack = |(s_ack_i & sel_q);
  assign slv_err = |(s_err_i & sel_q);
  assign s_cyc_o = (state_q == ACCESS) ? sel_q : '0;
  assign s_stb_o = (state_q == ACCESS) ? sel_q : '0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    to_d      = timeout_o;
    latch_req = 1'b0;
    cap_dat   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          latch_req = 1'b1;
          if (match_valid) begin
            sel_d   = match_oh;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // abort beats any response arriving in the same cycle
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (slv_err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (slv_ack) begin
          ack_d   = 1'b1;
          cap_dat = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q     <= '0;
      cnt_q     <= '0;
      m_ack_o   <= 1'b0;
      m_err_o   <= 1'b0;
      m_dat_o   <= '0;
      timeout_o <= 1'b0;
      s_we_o    <= 1'b0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      s_sel_o   <= '0;
    end else begin
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      m_ack_o   <= ack_d;
      m_err_o   <= err_d;
      timeout_o <= to_d;
      if (latch_req) begin
        s_we_o  <= m_we_i;
        s_adr_o <= m_adr_i;
        s_dat_o <= m_dat_i;
        s_sel_o <= m_sel_i;
      end
      if (cap_dat) m_dat_o <= s_dat_i[sel_idx*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_wb_addr_router.sv
// tb/tb_wb_addr_router.sv - self-checking bench for wb_addr_router
module tb_wb_addr_router;

  localparam int TMO = 8;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_SILENT = 3;

  logic        clk, rst_n;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat, m_rdat;
  logic [3:0]  m_sel;
  logic        m_ack, m_err;
  logic [95:0] prefix, mask;
  logic [2:0]  s_cyc, s_stb, s_ack, s_err;
  logic        s_we;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic [95:0] s_rdat;
  logic        tmo;

  wb_addr_router #(.NUM_SLAVES(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
    .slv_adr_prefix_i(prefix), .slv_adr_mask_i(mask),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat), .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] pfx[3] = '{32'h0000_0000, 32'h1000_0000, 32'h8000_0000};
  logic [31:0] msk[3] = '{32'hFFFF_0000, 32'hF000_0000, 32'h8000_0000};

  // slave models: respond once their strobe has been seen for more than wt_s cycles
  int          mode_s[3];
  int          wt_s[3];
  int          cnt_s[3];
  logic [31:0] rd_s[3];
  bit          noise;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (s_stb[k]) begin
        cnt_s[k] = cnt_s[k] + 1;
        s_ack[k] = (cnt_s[k] > wt_s[k]) && (mode_s[k] == M_ACK || mode_s[k] == M_BOTH);
        s_err[k] = (cnt_s[k] > wt_s[k]) && (mode_s[k] == M_ERR || mode_s[k] == M_BOTH);
      end else begin
        cnt_s[k] = 0;
        s_ack[k] = noise;
        s_err[k] = noise;
      end
    end
    s_rdat = {rd_s[2], rd_s[1], rd_s[0]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 3; k++)
      if ((a & msk[k]) == pfx[k]) return k;
    return -1;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] sel, output int lat, output logic got_ack,
                         output logic got_err, output logic [2:0] stb_seen, output int cyc_cnt);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = a; m_dat = wd; m_sel = sel;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; stb_seen = '0; cyc_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      stb_seen = stb_seen | s_stb;
      if (s_cyc != 3'b000) cyc_cnt++;
      if (m_ack || m_err) begin
        lat = i; got_ack = m_ack; got_err = m_err;
        break;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  // full transaction with bench-computed expectations
  task automatic do_check(input string tag, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [3:0] sel,
                          input logic e_ack, input logic e_err, input int e_lat,
                          input logic [31:0] e_dat, input logic [2:0] e_stb, input logic e_to);
    int lat, cyc_cnt;
    logic ga, ge;
    logic [2:0] stb_seen;
    run_txn(a, we, wd, sel, lat, ga, ge, stb_seen, cyc_cnt);
    chk({tag, " ack"}, ga, e_ack);
    chk({tag, " err"}, ge, e_err);
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " stb one-hot"}, stb_seen, e_stb);
    chk({tag, " cyc cycles"}, cyc_cnt, (e_stb == 3'b000) ? 0 : e_lat - 1);
    chk({tag, " s_adr"}, s_adr, a);
    chk({tag, " s_dat/sel/we"}, {s_dat, s_sel, s_we}, {wd, sel, we});
    @(posedge clk); @(negedge clk);
    chk({tag, " pulse width"}, {m_ack, m_err}, 2'b00);
    chk({tag, " m_dat"}, m_rdat, e_dat);
    chk({tag, " timeout"}, tmo, e_to);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  sel;
    int          mode;
    int          wt;
    logic [31:0] rd;
    logic        e_ack;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_dat;
    logic [2:0]  e_stb;
    logic        e_to;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] exp_dat;
    logic        exp_to;
    logic        seen;

    vecs[0] = '{32'h0000_0040, 1'b0, 32'h0, 4'hF, M_ACK, 3, 32'hDEAD_BEEF, 1'b1, 1'b0, 5, 32'hDEAD_BEEF, 3'b001, 1'b0};
    vecs[1] = '{32'h1000_0004, 1'b1, 32'h1234_5678, 4'b0011, M_ACK, 0, 32'hCAFE_0001, 1'b1, 1'b0, 2, 32'hCAFE_0001, 3'b010, 1'b0};
    vecs[2] = '{32'h2000_0000, 1'b0, 32'h0, 4'hF, M_ACK, 0, 32'h0BAD_0BAD, 1'b0, 1'b1, 1, 32'hCAFE_0001, 3'b000, 1'b0};
    vecs[3] = '{32'h8000_0010, 1'b0, 32'h0, 4'hF, M_BOTH, 1, 32'h5555_5555, 1'b0, 1'b1, 3, 32'hCAFE_0001, 3'b100, 1'b0};
    vecs[4] = '{32'h0000_1234, 1'b1, 32'hAAAA_0000, 4'b1000, M_ERR, 0, 32'h1111_1111, 1'b0, 1'b1, 2, 32'hCAFE_0001, 3'b001, 1'b0};
    vecs[5] = '{32'h1FFF_FFFC, 1'b0, 32'h0, 4'hF, M_ACK, 7, 32'hA5A5_A5A5, 1'b1, 1'b0, 9, 32'hA5A5_A5A5, 3'b010, 1'b0};
    vecs[6] = '{32'h8000_0000, 1'b0, 32'h0, 4'hF, M_SILENT, 0, 32'h0, 1'b0, 1'b1, TMO + 1, 32'hA5A5_A5A5, 3'b100, 1'b1};

    prefix = {pfx[2], pfx[1], pfx[0]};
    mask   = {msk[2], msk[1], msk[0]};
    for (int k = 0; k < 3; k++) begin
      mode_s[k] = M_ACK; wt_s[k] = 0; cnt_s[k] = 0; rd_s[k] = '0;
    end
    noise = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset master outs", {m_ack, m_err, m_rdat, tmo}, '0);
    chk("reset slave outs", {s_cyc, s_stb, s_we, s_adr, s_sel}, '0);
    chk("reset s_dat", s_dat, '0);
    rst_n = 1'b1;
    @(negedge clk);

    noise = 1'b1;
    foreach (vecs[i]) begin
      int t;
      t = decode(vecs[i].addr);
      for (int k = 0; k < 3; k++) begin
        mode_s[k] = M_ACK; wt_s[k] = 0; rd_s[k] = $urandom;
      end
      if (t >= 0) begin
        mode_s[t] = vecs[i].mode; wt_s[t] = vecs[i].wt; rd_s[t] = vecs[i].rd;
      end
      do_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].sel,
               vecs[i].e_ack, vecs[i].e_err, vecs[i].e_lat, vecs[i].e_dat, vecs[i].e_stb, vecs[i].e_to);
    end

    exp_dat = 32'hA5A5_A5A5;
    exp_to  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, wd;
      logic        we, e_ack, e_err;
      logic [3:0]  sel;
      logic [2:0]  e_stb;
      int          t, md, wt, e_lat;
      case ($urandom_range(3))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {4'h1, 28'($urandom)};
        2:       a = {1'b1, 31'($urandom)};
        default: a = $urandom;
      endcase
      we = 1'($urandom); wd = $urandom; sel = 4'($urandom);
      md = ($urandom_range(9) == 0) ? M_SILENT : int'($urandom_range(2));
      wt = $urandom_range(7);
      noise = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
        mode_s[k] = md; wt_s[k] = wt; rd_s[k] = $urandom;
      end
      t = decode(a);
      if (t < 0) begin
        e_ack = 1'b0; e_err = 1'b1; e_lat = 1; e_stb = 3'b000;
      end else begin
        e_stb = 3'b001 << t;
        if (md == M_SILENT || wt >= TMO) begin
          e_ack = 1'b0; e_err = 1'b1; e_lat = TMO + 1; exp_to = 1'b1;
        end else begin
          e_ack = (md == M_ACK); e_err = !e_ack; e_lat = wt + 2;
          if (e_ack) exp_dat = rd_s[t];
        end
      end
      do_check($sformatf("rnd%0d", n), a, we, wd, sel, e_ack, e_err, e_lat, exp_dat, e_stb, exp_to);
    end

    // master abort during a slave1 access
    noise = 1'b0;
    mode_s[1] = M_SILENT;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h1000_0100; m_sel = 4'hF;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("abort stb active", s_stb, 3'b010);
    m_cyc = 1'b0; m_stb = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); seen = seen | m_ack | m_err; end
    chk("abort no response", seen, 1'b0);
    chk("abort lines dropped", {s_cyc, s_stb}, '0);
    chk("abort timeout sticky", tmo, 1'b1);

    // asynchronous reset during a slave0 access
    mode_s[0] = M_SILENT;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_0100;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("rst mid cyc active", s_cyc, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("rst mid slave lines", {s_cyc, s_stb}, '0);
    chk("rst mid master outs", {m_ack, m_err, m_rdat, tmo}, '0);
    chk("rst mid latched", {s_we, s_adr, s_dat, s_sel}, '0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); seen = seen | m_ack | m_err; end
    chk("rst no response", seen, 1'b0);
    mode_s[0] = M_ACK; wt_s[0] = 0; rd_s[0] = 32'h0F0F_1234;
    do_check("post-rst", 32'h0000_0008, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2, 32'h0F0F_1234, 3'b001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
